fast_frame_sequencer: RTL and testbench
=======================================

FAST_FRAME_SEQUENCER -- requirements
Module: fast_frame_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 640: pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480: lines per frame.
REQ-003 SHALL have parameter MAX_FEAT, default 1024: features kept per frame.
REQ-004 SHALL have parameter FLUSH_MAX, default 65535: maximum FLUSH cycles before timeout.
REQ-005 SHALL have port i_clk, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port i_frame_req, input, 1: start one frame; sampled only in IDLE.
REQ-008 SHALL have port i_abort, input, 1: cancel the current frame.
REQ-009 SHALL have port o_mem_rd, output, 1: pixel-memory read strobe.
REQ-010 SHALL have port o_mem_addr, output, 19: raster address, equal to y*WIDTH+x.
REQ-011 SHALL have port i_mem_data, input, 8: read data, valid one cycle after o_mem_rd.
REQ-012 SHALL have port o_det_pixel, output, 8: pixel to the detector's i_pixel.
REQ-013 SHALL have port o_det_start, output, 1: pulse to the detector's i_start.
REQ-014 SHALL have port i_det_flag, input, 1: detector feature-valid strobe.
REQ-015 SHALL have port i_det_end, input, 1: detector end-of-frame strobe.
REQ-016 SHALL have port o_feat_keep, output, 1: the downstream store writes this feature.
REQ-017 SHALL have port o_feat_cnt, output, 11: features kept in the current/last frame.
REQ-018 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-019 SHALL have port o_done, output, 1: one-cycle end-of-frame pulse.
REQ-020 SHALL have port o_timeout, output, 1: sticky flag; the last frame ended by timeout.
REQ-021 SHALL have port o_cycle_cnt, output, 32: cycles spent in the current/last frame.

Function
REQ-022 SHALL implement states IDLE, FEED, FLUSH and DONE.
REQ-023 SHALL go IDLE->FEED on i_frame_req, clearing o_feat_cnt, o_timeout, the address counter and the flush counter.
REQ-024 SHALL ignore i_frame_req outside IDLE.
REQ-025 In FEED, SHALL assert o_mem_rd for exactly WIDTH*HEIGHT consecutive cycles, addresses 0..WIDTH*HEIGHT-1, incrementing by 1 per cycle.
REQ-026 SHALL go FEED->FLUSH in the cycle after the last address is issued.
REQ-027 SHALL register i_mem_data into o_det_pixel, so a pixel whose address is issued at cycle t appears at t+2.
REQ-028 SHALL drive o_det_pixel to 0 whenever no read data is pending.
REQ-029 SHALL assert o_det_start for exactly one cycle, the cycle in which o_det_pixel carries address 0.
REQ-030 SHALL count flush cycles in FLUSH and go FLUSH->DONE on i_det_end.
REQ-031 SHALL, if FLUSH_MAX flush cycles elapse without i_det_end, set o_timeout and go FLUSH->DONE.
REQ-032 SHALL treat i_det_end and timeout in the same cycle as a normal end, with o_timeout staying 0.
REQ-033 SHALL ignore i_det_end while in FEED.
REQ-034 SHALL assert o_done for the single DONE cycle, then return to IDLE.
REQ-035 SHALL compute o_feat_keep = i_det_flag & o_busy & (o_feat_cnt < MAX_FEAT), combinationally.
REQ-036 SHALL increment o_feat_cnt on each o_feat_keep, saturating at MAX_FEAT, including a flag coincident with i_det_end.
REQ-037 SHALL hold o_feat_cnt and o_timeout in IDLE until the next frame start.
REQ-038 SHALL, on i_abort in FEED or FLUSH, go to IDLE next cycle with no o_done, deassert o_mem_rd, and drop pending pixels to 0.
REQ-039 SHALL give i_abort priority over i_det_end.

Reset
REQ-040 SHALL, while i_rst is high, enter IDLE with all outputs 0 (o_mem_addr, o_det_pixel, o_feat_cnt, o_cycle_cnt included) and the read pipeline cleared.
REQ-041 SHALL, on reset mid-frame, behave as abort with all counters cleared.

Configuration
REQ-042 SHALL, with FAST_SEQ_STATS_EN defined, clear o_cycle_cnt on frame start, increment it every cycle in FEED, FLUSH and DONE (saturating at all ones), and hold it in IDLE.
REQ-043 SHALL, without FAST_SEQ_STATS_EN, keep the o_cycle_cnt port and drive it constant 0, with no counter logic.

Structure
REQ-044 SHALL place the state enum, the 19-bit address width constant and the 11-bit count width constant in shared package fast_seq_pkg.
REQ-045 SHALL put the raster address counter (x/y wrap, last-address flag) in sub-module fast_seq_addr_gen.

Verification (WIDTH=8, HEIGHT=4, MAX_FEAT=3, FLUSH_MAX=20)
REQ-046 SHALL cover normal frame: i_frame_req at cycle 0 -> o_mem_rd for 32 cycles with addresses 0..31, o_det_start 2 cycles after address 0, pixels in order; i_det_end at flush cycle 5 -> o_done once, o_timeout=0.
REQ-047 SHALL cover feature saturation: 5 i_det_flag pulses, one coincident with i_det_end -> o_feat_keep on the first 3 only, o_feat_cnt=3.
REQ-048 SHALL cover timeout: no i_det_end -> o_timeout=1 after 20 flush cycles, o_done pulse, o_feat_cnt held.
REQ-049 SHALL cover abort: i_abort at address 10 -> IDLE next cycle, no o_done, o_det_pixel=0 after 2 cycles; a new i_frame_req then restarts at address 0.
REQ-050 SHALL cover reset and stray requests: i_rst during FLUSH -> all outputs 0 next cycle; i_frame_req during FEED -> ignored, exactly 32 reads.
REQ-051 SHALL cover stats: with FAST_SEQ_STATS_EN defined, the normal frame gives o_cycle_cnt=32+5+1=38; without it, o_cycle_cnt=0.

Source files
------------

// File: rtl/fast_seq_pkg.sv
// Shared definitions for the fast frame sequencer: sequencer state encoding
// and the fixed widths of the raster address and feature count buses.
package fast_seq_pkg;

  localparam int ADDR_W = 19;  // raster address width (y*WIDTH+x)
  localparam int CNT_W  = 11;  // feature count width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fast_seq_addr_gen.sv
// Raster address generator. Walks x across a line and y down the frame,
// producing the linear address y*WIDTH+x one step per enabled cycle and
// flagging the final pixel so the sequencer knows the feed is complete.
//
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset
//   i_clr   return to address 0 (frame start / abort); wins over i_en
//   i_en    advance one pixel
//   o_addr  current raster address
//   o_last  current address is the last pixel of the frame
module fast_seq_addr_gen
  import fast_seq_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              x_end, y_end;

  assign x_end  = (x_q == XW'(WIDTH - 1));
  assign y_end  = (y_q == YW'(HEIGHT - 1));
  assign o_last = x_end && y_end;
  assign o_addr = addr_q;

  // The linear address is kept as its own counter rather than multiplied
  // out of x/y, so no multiplier sits on the address path.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (i_clr) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (i_en) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      addr_d = o_last ? '0 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/fast_frame_sequencer.sv
// Frame sequencer for a FAST-style feature detector. On request it streams
// one frame of pixels from pixel memory into the detector, waits for the
// detector to flush (bounded by a timeout), counts kept features and pulses
// done. Optional cycle statistics are built only when FAST_SEQ_STATS_EN is
// defined; otherwise o_cycle_cnt is tied to 0.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for i_frame_req; counters/flags of last frame held
//   ST_FEED  | issuing WIDTH*HEIGHT memory reads, one address per cycle
//   ST_FLUSH | waiting for i_det_end, at most FLUSH_MAX cycles
//   ST_DONE  | single-cycle o_done pulse, then back to IDLE
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_frame_req, i_abort    frame start (IDLE only) / cancel (FEED, FLUSH)
//   o_mem_rd, o_mem_addr    pixel memory read strobe and raster address
//   i_mem_data              read data, one cycle after o_mem_rd
//   o_det_pixel, o_det_start pixel stream and first-pixel pulse to detector
//   i_det_flag, i_det_end   detector feature strobe / end-of-frame strobe
//   o_feat_keep, o_feat_cnt feature write enable and kept-feature count
//   o_busy, o_done          not-IDLE status / end-of-frame pulse
//   o_timeout               sticky: last frame ended by flush timeout
//   o_cycle_cnt             cycles spent in the current/last frame
module fast_frame_sequencer
  import fast_seq_pkg::*;
#(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int MAX_FEAT  = 1024,
  parameter int FLUSH_MAX = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_req,
  input  logic              i_abort,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_det_pixel,
  output logic              o_det_start,
  input  logic              i_det_flag,
  input  logic              i_det_end,
  output logic              o_feat_keep,
  output logic [CNT_W-1:0]  o_feat_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [31:0]       o_cycle_cnt
);

  localparam int                 FLUSH_W    = $clog2(FLUSH_MAX + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_MAX - 1);
  localparam logic [CNT_W-1:0]   FEAT_MAX   = CNT_W'(MAX_FEAT);

  seq_state_e         state_q;
  logic [FLUSH_W-1:0] flush_q;
  logic [CNT_W-1:0]   feat_cnt_q;
  logic               timeout_q;
  logic               rd_pend_q;
  logic               first_pend_q;
  logic               det_start_q;
  logic [7:0]         det_pixel_q;

  logic frame_start;
  logic abort_act;
  logic addr_last;

  assign frame_start = (state_q == ST_IDLE) && i_frame_req;
  assign abort_act   = i_abort && ((state_q == ST_FEED) || (state_q == ST_FLUSH));

  fast_seq_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_addr_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (frame_start || abort_act),
    .i_en   (state_q == ST_FEED),
    .o_addr (o_mem_addr),
    .o_last (addr_last)
  );

  assign o_mem_rd    = (state_q == ST_FEED);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_feat_keep = i_det_flag && o_busy && (feat_cnt_q < FEAT_MAX);
  assign o_feat_cnt  = feat_cnt_q;
  assign o_timeout   = timeout_q;
  assign o_det_pixel = det_pixel_q;
  assign o_det_start = det_start_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      flush_q      <= '0;
      feat_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      first_pend_q <= 1'b0;
      det_start_q  <= 1'b0;
      det_pixel_q  <= '0;
    end else begin
      // Two-stage read pipeline: memory returns data the cycle after the
      // strobe, and it is registered once more toward the detector. An
      // abort discards everything still in flight.
      rd_pend_q    <= o_mem_rd && !abort_act;
      first_pend_q <= o_mem_rd && (o_mem_addr == '0) && !abort_act;
      det_start_q  <= first_pend_q && !abort_act;
      det_pixel_q  <= (rd_pend_q && !abort_act) ? i_mem_data : '0;

      if (o_feat_keep) begin
        feat_cnt_q <= feat_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (i_frame_req) begin
            state_q    <= ST_FEED;
            flush_q    <= '0;
            feat_cnt_q <= '0;
            timeout_q  <= 1'b0;
          end
        end
        ST_FEED: begin
          if (i_abort) begin
            state_q <= ST_IDLE;
          end else if (addr_last) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // A detector end arriving on the timeout cycle is a normal end.
          if (i_abort) begin
            state_q <= ST_IDLE;
          end else if (i_det_end) begin
            state_q <= ST_DONE;
          end else if (flush_q == FLUSH_LAST) begin
            state_q   <= ST_DONE;
            timeout_q <= 1'b1;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FAST_SEQ_STATS_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_cnt_q <= '0;
    end else if (frame_start) begin
      cycle_cnt_q <= '0;
    end else if ((state_q != ST_IDLE) && (cycle_cnt_q != '1)) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  assign o_cycle_cnt = cycle_cnt_q;
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_fast_frame_sequencer.sv
module tb_fast_frame_sequencer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int MF = 3;
  localparam int FM = 20;
  localparam int N  = W * H;
`ifdef FAST_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_frame_req = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_det_flag = 1'b0;
  logic        i_det_end = 1'b0;
  logic [7:0]  i_mem_data;
  logic        o_mem_rd;
  logic [18:0] o_mem_addr;
  logic [7:0]  o_det_pixel;
  logic        o_det_start;
  logic        o_feat_keep;
  logic [10:0] o_feat_cnt;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout;
  logic [31:0] o_cycle_cnt;

  always #5 clk = ~clk;

  fast_frame_sequencer #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .MAX_FEAT  (MF),
    .FLUSH_MAX (FM)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_frame_req (i_frame_req),
    .i_abort     (i_abort),
    .o_mem_rd    (o_mem_rd),
    .o_mem_addr  (o_mem_addr),
    .i_mem_data  (i_mem_data),
    .o_det_pixel (o_det_pixel),
    .o_det_start (o_det_start),
    .i_det_flag  (i_det_flag),
    .i_det_end   (i_det_end),
    .o_feat_keep (o_feat_keep),
    .o_feat_cnt  (o_feat_cnt),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_timeout   (o_timeout),
    .o_cycle_cnt (o_cycle_cnt)
  );

  // Pixel memory: answers a read one cycle later, garbage otherwise.
  logic [7:0] mem [N];
  always @(posedge clk) begin
    if (o_mem_rd && int'(o_mem_addr) < N) i_mem_data <= mem[int'(o_mem_addr)];
    else i_mem_data <= 8'($urandom);
  end

  // Reference model: frame timeline expressed as cycle offset since start.
  bit         m_valid = 0;
  bit         m_active = 0;
  int         m_k = 0;       // 1-based cycle number within the frame
  int         m_done_k = 0;  // frame cycle carrying o_done, 0 = not yet known
  int         m_feat = 0;
  bit         m_to = 0;
  int         m_cyc = 0;
  int         tc = 0;        // global cycle index
  logic [7:0] exp_pix [int];
  bit         exp_start [int];

  int n_chk = 0, n_pass = 0;
  int n_rd = 0, n_done = 0, n_keep = 0, start_tc = -1;
  int flag_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, tc);
  endtask

  task automatic compare();
    logic       e_rd, e_done, e_keep, e_start;
    logic [7:0] e_pix;
    int         e_addr, e_cyc;
    if (!m_valid) return;
    e_rd    = m_active && (m_k <= N);
    e_addr  = e_rd ? m_k - 1 : 0;
    e_done  = m_active && (m_k == m_done_k);
    e_keep  = i_det_flag && m_active && (m_feat < MF);
    e_pix   = exp_pix.exists(tc) ? exp_pix[tc] : 8'd0;
    e_start = exp_start.exists(tc) ? exp_start[tc] : 1'b0;
    e_cyc   = STATS ? m_cyc : 0;
    chk("mem_rd", 32'(o_mem_rd), 32'(e_rd));
    chk("mem_addr", 32'(o_mem_addr), e_addr);
    chk("det_pixel", 32'(o_det_pixel), 32'(e_pix));
    chk("det_start", 32'(o_det_start), 32'(e_start));
    chk("feat_keep", 32'(o_feat_keep), 32'(e_keep));
    chk("feat_cnt", 32'(o_feat_cnt), m_feat);
    chk("busy", 32'(o_busy), 32'(m_active));
    chk("done", 32'(o_done), 32'(e_done));
    chk("timeout", 32'(o_timeout), 32'(m_to));
    chk("cycle_cnt", o_cycle_cnt, e_cyc);
    if (o_mem_rd === 1'b1) n_rd++;
    if (o_done === 1'b1) n_done++;
    if (o_feat_keep === 1'b1) n_keep++;
    if (o_det_start === 1'b1) start_tc = tc;
    if (exp_pix.exists(tc)) exp_pix.delete(tc);
    if (exp_start.exists(tc)) exp_start.delete(tc);
  endtask

  task automatic advance();
    if (i_rst) begin
      m_valid = 1; m_active = 0; m_k = 0; m_done_k = 0;
      m_feat = 0; m_to = 0; m_cyc = 0;
      exp_pix.delete();
      exp_start.delete();
    end else if (m_valid) begin
      if (!m_active) begin
        if (i_frame_req) begin
          m_active = 1; m_k = 1; m_done_k = 0; m_feat = 0; m_to = 0; m_cyc = 0;
        end
      end else begin
        if (i_det_flag && m_feat < MF) m_feat++;
        m_cyc++;
        if (m_k == m_done_k) begin
          m_active = 0;
        end else if (i_abort) begin
          m_active = 0;
          if (exp_pix.exists(tc + 1)) exp_pix.delete(tc + 1);
          if (exp_start.exists(tc + 1)) exp_start.delete(tc + 1);
        end else begin
          if (m_k <= N) begin
            exp_pix[tc + 2] = mem[m_k - 1];
            if (m_k == 1) exp_start[tc + 2] = 1'b1;
          end else if (i_det_end) begin
            m_done_k = m_k + 1;
          end else if (m_k - N == FM) begin
            m_done_k = m_k + 1;
            m_to = 1;
          end
          m_k++;
        end
      end
    end
    tc++;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic step(input bit rq, input bit ab, input bit fl, input bit de, input bit rs);
    i_frame_req = rq; i_abort = ab; i_det_flag = fl; i_det_end = de; i_rst = rs;
    @(negedge clk);
    compare();
    @(posedge clk);
    advance();
    #1;
  endtask

  // Frame starting at offset 0; end_f = flush cycle of i_det_end (0 = none),
  // other offsets are -1 when unused. Returns in the cycle after the last one.
  task automatic run_frame(input int end_f, input int abort_o, input int stray_o, input int rst_o);
    int last_o;
    if (abort_o >= 0) last_o = abort_o;
    else if (rst_o >= 0) last_o = rst_o;
    else if (end_f > 0) last_o = N + end_f + 1;
    else last_o = N + FM + 1;
    for (int o = 0; o <= last_o; o++) begin
      bit fl;
      fl = 0;
      foreach (flag_q[i]) if (flag_q[i] == o) fl = 1;
      step((o == 0) || (o == stray_o), o == abort_o, fl, (end_f > 0) && (o == N + end_f), o == rst_o);
    end
  endtask

  initial begin
    int b_rd, b_done, b_keep, req_tc;
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);

    repeat (3) step(0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0);

    // Normal frame, detector end on flush cycle 5.
    flag_q = '{4, 20};
    b_rd = n_rd; b_done = n_done; req_tc = tc;
    run_frame(5, -1, -1, -1);
    chk("A_reads", n_rd - b_rd, 32);
    chk("A_done_pulses", n_done - b_done, 1);
    chk("A_start_latency", start_tc - req_tc, 3);
    chk("A_feat_cnt", 32'(o_feat_cnt), 2);
    chk("A_timeout", 32'(o_timeout), 0);
    chk("A_cycle_cnt", o_cycle_cnt, STATS ? 38 : 0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("A_feat_hold", 32'(o_feat_cnt), 2);

    // Feature saturation; last flag coincides with i_det_end.
    flag_q = '{3, 8, 30, 34, 37};
    b_keep = n_keep;
    run_frame(5, -1, -1, -1);
    chk("B_keeps", n_keep - b_keep, 3);
    chk("B_feat_cnt", 32'(o_feat_cnt), 3);
    step(0, 0, 0, 0, 0);

    // Flush timeout.
    flag_q = '{5};
    b_done = n_done;
    run_frame(0, -1, -1, -1);
    chk("C_timeout", 32'(o_timeout), 1);
    chk("C_done_pulses", n_done - b_done, 1);
    chk("C_feat_cnt", 32'(o_feat_cnt), 1);
    chk("C_cycle_cnt", o_cycle_cnt, STATS ? 53 : 0);
    repeat (4) step(0, 0, 0, 0, 0);
    chk("C_timeout_sticky", 32'(o_timeout), 1);

    // Abort while address 10 is issued, then restart.
    flag_q = {};
    b_done = n_done;
    run_frame(0, 11, -1, -1);
    chk("D_busy_after_abort", 32'(o_busy), 0);
    chk("D_rd_after_abort", 32'(o_mem_rd), 0);
    step(0, 0, 0, 0, 0);
    chk("D_pixel_cleared", 32'(o_det_pixel), 0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("D_no_done", n_done - b_done, 0);
    b_rd = n_rd; req_tc = tc;
    run_frame(3, -1, -1, -1);
    chk("D_restart_reads", n_rd - b_rd, 32);
    chk("D_restart_start", start_tc - req_tc, 3);

    // Reset during flush cycle 3.
    flag_q = '{2};
    run_frame(0, -1, -1, N + 3);
    chk("E_rst_busy", 32'(o_busy), 0);
    chk("E_rst_feat_cnt", 32'(o_feat_cnt), 0);
    chk("E_rst_addr", 32'(o_mem_addr), 0);
    chk("E_rst_pixel", 32'(o_det_pixel), 0);
    chk("E_rst_cycle_cnt", o_cycle_cnt, 0);
    chk("E_rst_done", 32'(o_done), 0);
    step(0, 0, 0, 0, 0);

    // Stray request while feeding.
    flag_q = {};
    b_rd = n_rd; b_done = n_done;
    run_frame(3, -1, 10, -1);
    chk("E_stray_reads", n_rd - b_rd, 32);
    chk("E_stray_done", n_done - b_done, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(19) == 0, $urandom_range(149) == 0, $urandom_range(3) == 0,
           $urandom_range(24) == 0, $urandom_range(799) == 0);
    end
    repeat (4) step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
